// File: rtl/iobus_copy_engine.sv
// IOBUS initiator that copies COUNT words from a source address to a destination address, with a sticky DONE_IRQ.
// Define IOBUS_COPY_ABORT_EN to add the ABORT input and the ABORTED status output.
module iobus_copy_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STRIDE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic              SRC_INC,
  input  logic              DST_INC,
  input  logic              IRQ_CLR,
`ifdef IOBUS_COPY_ABORT_EN
  input  logic              ABORT,
  output logic              ABORTED,
`endif
  input  logic [DATA_W-1:0] IOBUS_IN,
  output logic [ADDR_W-1:0] IOBUS_ADDR,
  output logic [DATA_W-1:0] IOBUS_OUT,
  output logic              IOBUS_WR,
  output logic              BUSY,
  output logic              DONE_IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_data;
  logic              r_src_inc;
  logic              r_dst_inc;
  logic              r_irq;
  logic              w_accept;
  logic              w_abort;

  assign w_accept = (r_state == S_IDLE) && START;

`ifdef IOBUS_COPY_ABORT_EN
  logic r_abort_pend;
  logic r_aborted;

  assign w_abort = ABORT && ((r_state == S_READ) || (r_state == S_WRITE));
  assign ABORTED = r_aborted;

  // The pending flag marks the upcoming FINISH as an aborted one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      if (r_state == S_FINISH)
        r_abort_pend <= 1'b0;
      else if (w_abort)
        r_abort_pend <= 1'b1;

      if ((r_state == S_FINISH) && r_abort_pend)
        r_aborted <= 1'b1;
      else if (IRQ_CLR || w_accept)
        r_aborted <= 1'b0;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (START) w_next = (COUNT == '0) ? S_FINISH : S_READ;
      S_READ:   w_next = w_abort ? S_FINISH : S_WRITE;
      S_WRITE:  w_next = ((r_rem == CNT_W'(1)) || w_abort) ? S_FINISH : S_READ;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus outputs decode from state and registers only, so IOBUS_IN never reaches an output.
  always_comb begin
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    unique case (r_state)
      S_READ:  IOBUS_ADDR = r_src;
      S_WRITE: begin
        IOBUS_ADDR = r_dst;
        IOBUS_OUT  = r_data;
        IOBUS_WR   = 1'b1;
      end
      default: ;
    endcase
  end

  assign BUSY     = (r_state != S_IDLE);
  assign DONE_IRQ = r_irq;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_data    <= '0;
      r_src_inc <= 1'b0;
      r_dst_inc <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (START) begin
          r_src     <= SRC_ADDR;
          r_dst     <= DST_ADDR;
          r_rem     <= COUNT;
          r_src_inc <= SRC_INC;
          r_dst_inc <= DST_INC;
        end
        S_READ:  r_data <= IOBUS_IN;
        S_WRITE: begin
          r_rem <= r_rem - CNT_W'(1);
          if (r_src_inc) r_src <= r_src + ADDR_W'(STRIDE);
          if (r_dst_inc) r_dst <= r_dst + ADDR_W'(STRIDE);
        end
        default: ;
      endcase
    end
  end

  // Completion set has priority over IRQ_CLR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_irq <= 1'b0;
    else if (r_state == S_FINISH)
      r_irq <= 1'b1;
    else if (IRQ_CLR)
      r_irq <= 1'b0;
  end

endmodule

// File: tb/tb_iobus_copy_engine.sv
// Directed self-checking bench for iobus_copy_engine with a combinational IOBUS responder and a write log.
module tb_iobus_copy_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [31:0] SRC_ADDR = '0;
  logic [31:0] DST_ADDR = '0;
  logic [15:0] COUNT = '0;
  logic        SRC_INC = 1'b0;
  logic        DST_INC = 1'b0;
  logic        IRQ_CLR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic        BUSY;
  logic        DONE_IRQ;
`ifdef IOBUS_COPY_ABORT_EN
  logic        ABORT = 1'b0;
  logic        ABORTED;
`endif

  int checks = 0;
  int errors = 0;
  int wr_n = 0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];

  iobus_copy_engine #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .STRIDE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .COUNT(COUNT), .SRC_INC(SRC_INC), .DST_INC(DST_INC), .IRQ_CLR(IRQ_CLR),
`ifdef IOBUS_COPY_ABORT_EN
    .ABORT(ABORT), .ABORTED(ABORTED),
`endif
    .IOBUS_IN(IOBUS_IN), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    case (IOBUS_ADDR)
      32'h1100_0000: IOBUS_IN = 32'h0000_A5A5;
      32'h0000_0100: IOBUS_IN = 32'd1;
      32'h0000_0104: IOBUS_IN = 32'd2;
      32'h0000_0108: IOBUS_IN = 32'd3;
      default:       IOBUS_IN = IOBUS_ADDR ^ 32'h5A5A_0000;
    endcase
  end

  always @(posedge CLK) begin
    if (IOBUS_WR && wr_n < 64) begin
      wr_a[wr_n] = IOBUS_ADDR;
      wr_d[wr_n] = IOBUS_OUT;
      wr_n++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input logic si, input logic di);
    SRC_ADDR = s; DST_ADDR = d; COUNT = n; SRC_INC = si; DST_INC = di; START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (IOBUS_WR !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", IOBUS_WR); end
    checks++; if (IOBUS_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", IOBUS_ADDR); end
    checks++; if (IOBUS_OUT !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 0", IOBUS_OUT); end
    checks++; if (DONE_IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", DONE_IRQ); end
  endtask

  task automatic test_single();
    kick(32'h1100_0000, 32'h1100_0020, 16'd1, 1'b0, 1'b0);
    checks++; if (IOBUS_ADDR !== 32'h1100_0000 || IOBUS_WR !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL single_read got addr %h wr %b busy %b exp 11000000 0 1", IOBUS_ADDR, IOBUS_WR, BUSY); end
    step();
    checks++; if (IOBUS_ADDR !== 32'h1100_0020 || IOBUS_OUT !== 32'h0000_A5A5 || IOBUS_WR !== 1'b1) begin
      errors++; $display("FAIL single_write got addr %h out %h wr %b exp 11000020 0000a5a5 1", IOBUS_ADDR, IOBUS_OUT, IOBUS_WR); end
    step();
    checks++; if (BUSY !== 1'b1 || IOBUS_WR !== 1'b0 || DONE_IRQ !== 1'b0) begin
      errors++; $display("FAIL single_finish got busy %b wr %b irq %b exp 1 0 0", BUSY, IOBUS_WR, DONE_IRQ); end
    step();
    checks++; if (BUSY !== 1'b0 || DONE_IRQ !== 1'b1) begin
      errors++; $display("FAIL single_done got busy %b irq %b exp 0 1", BUSY, DONE_IRQ); end
    IRQ_CLR = 1'b1;
    step();
    IRQ_CLR = 1'b0;
    checks++; if (DONE_IRQ !== 1'b0) begin errors++; $display("FAIL single_irqclr got %b exp 0", DONE_IRQ); end
  endtask

  task automatic test_incr();
    int base;
    base = wr_n;
    kick(32'h0000_0100, 32'h1100_0040, 16'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (IOBUS_ADDR !== 32'h100 + 32'(4 * k) || IOBUS_WR !== 1'b0) begin
        errors++; $display("FAIL incr_read%0d got addr %h wr %b exp %h 0", k, IOBUS_ADDR, IOBUS_WR, 32'h100 + 32'(4 * k)); end
      step();
      checks++; if (IOBUS_ADDR !== 32'h1100_0040 || IOBUS_OUT !== 32'(k + 1) || IOBUS_WR !== 1'b1) begin
        errors++; $display("FAIL incr_write%0d got addr %h out %h exp 11000040 %h", k, IOBUS_ADDR, IOBUS_OUT, 32'(k + 1)); end
      step();
    end
    checks++; if (BUSY !== 1'b1 || IOBUS_WR !== 1'b0) begin
      errors++; $display("FAIL incr_finish got busy %b wr %b exp 1 0", BUSY, IOBUS_WR); end
    step();
    checks++; if (BUSY !== 1'b0 || DONE_IRQ !== 1'b1 || wr_n - base !== 3) begin
      errors++; $display("FAIL incr_done got busy %b irq %b writes %0d exp 0 1 3", BUSY, DONE_IRQ, wr_n - base); end
    IRQ_CLR = 1'b1; step(); IRQ_CLR = 1'b0;
  endtask

  task automatic test_zero();
    int base;
    base = wr_n;
    kick(32'h0000_0100, 32'h1100_0040, 16'd0, 1'b1, 1'b1);
    checks++; if (BUSY !== 1'b1 || IOBUS_WR !== 1'b0 || IOBUS_ADDR !== 32'h0) begin
      errors++; $display("FAIL zero_finish got busy %b wr %b addr %h exp 1 0 0", BUSY, IOBUS_WR, IOBUS_ADDR); end
    step();
    checks++; if (BUSY !== 1'b0 || DONE_IRQ !== 1'b1 || wr_n !== base) begin
      errors++; $display("FAIL zero_done got busy %b irq %b writes %0d exp 0 1 0", BUSY, DONE_IRQ, wr_n - base); end
  endtask

  task automatic test_start_ignored();
    kick(32'h0000_0200, 32'h0000_0300, 16'd2, 1'b1, 1'b1);
    SRC_ADDR = 32'h900; DST_ADDR = 32'h980; COUNT = 16'd7; START = 1'b1;
    step();
    START = 1'b0;
    checks++; if (IOBUS_ADDR !== 32'h300 || IOBUS_OUT !== 32'h5A5A_0200 || IOBUS_WR !== 1'b1) begin
      errors++; $display("FAIL ign_write0 got addr %h out %h exp 00000300 5a5a0200", IOBUS_ADDR, IOBUS_OUT); end
    step();
    checks++; if (IOBUS_ADDR !== 32'h204) begin errors++; $display("FAIL ign_read1 got %h exp 00000204", IOBUS_ADDR); end
    step();
    checks++; if (IOBUS_ADDR !== 32'h304 || IOBUS_OUT !== 32'h5A5A_0204) begin
      errors++; $display("FAIL ign_write1 got addr %h out %h exp 00000304 5a5a0204", IOBUS_ADDR, IOBUS_OUT); end
    step();
    checks++; if (BUSY !== 1'b1 || IOBUS_WR !== 1'b0) begin
      errors++; $display("FAIL ign_finish got busy %b wr %b exp 1 0", BUSY, IOBUS_WR); end
    IRQ_CLR = 1'b1;
    step();
    checks++; if (DONE_IRQ !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL irq_set_wins got irq %b busy %b exp 1 0", DONE_IRQ, BUSY); end
    step();
    IRQ_CLR = 1'b0;
    checks++; if (DONE_IRQ !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL irq_clr_next got irq %b busy %b exp 0 0", DONE_IRQ, BUSY); end
  endtask

  task automatic test_wrap();
    // DONE_IRQ is set beforehand; START together with IRQ_CLR must accept and clear.
    kick(32'h0, 32'h1100_0040, 16'd0, 1'b0, 1'b0);
    step();
    IRQ_CLR = 1'b1;
    kick(32'hFFFF_FFFC, 32'h1100_0040, 16'd2, 1'b1, 1'b0);
    IRQ_CLR = 1'b0;
    checks++; if (DONE_IRQ !== 1'b0 || BUSY !== 1'b1 || IOBUS_ADDR !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL start_clr got irq %b busy %b addr %h exp 0 1 fffffffc", DONE_IRQ, BUSY, IOBUS_ADDR); end
    step();
    checks++; if (IOBUS_OUT !== 32'hA5A5_FFFC) begin errors++; $display("FAIL wrap_data0 got %h exp a5a5fffc", IOBUS_OUT); end
    step();
    checks++; if (IOBUS_ADDR !== 32'h0 || IOBUS_WR !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL wrap_read1 got addr %h wr %b exp 00000000 0", IOBUS_ADDR, IOBUS_WR); end
    step();
    checks++; if (IOBUS_OUT !== 32'h5A5A_0000 || IOBUS_WR !== 1'b1) begin
      errors++; $display("FAIL wrap_data1 got %h exp 5a5a0000", IOBUS_OUT); end
    step(); step();
    IRQ_CLR = 1'b1; step(); IRQ_CLR = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    kick(32'h0000_0400, 32'h0000_0500, 16'd4, 1'b1, 1'b1);
    step();
    checks++; if (IOBUS_WR !== 1'b1) begin errors++; $display("FAIL mid_wr_before got %b exp 1", IOBUS_WR); end
    RST = 1'b1;
    #1;
    checks++; if (IOBUS_WR !== 1'b0 || BUSY !== 1'b0 || IOBUS_ADDR !== 32'h0 || IOBUS_OUT !== 32'h0) begin
      errors++; $display("FAIL mid_async got wr %b busy %b addr %h out %h exp 0 0 0 0", IOBUS_WR, BUSY, IOBUS_ADDR, IOBUS_OUT); end
    step();
    RST = 1'b0;
    step();
    base = wr_n;
    kick(32'h1100_0000, 32'h1100_0020, 16'd1, 1'b0, 1'b0);
    step(); step(); step();
    checks++; if (wr_n - base !== 1 || wr_a[base] !== 32'h1100_0020 || wr_d[base] !== 32'h0000_A5A5) begin
      errors++; $display("FAIL mid_restart got writes %0d addr %h data %h exp 1 11000020 0000a5a5",
                         wr_n - base, wr_a[base], wr_d[base]); end
    checks++; if (DONE_IRQ !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL mid_restart_done got irq %b busy %b exp 1 0", DONE_IRQ, BUSY); end
    IRQ_CLR = 1'b1; step(); IRQ_CLR = 1'b0;
  endtask

`ifdef IOBUS_COPY_ABORT_EN
  task automatic test_abort();
    int base;
    base = wr_n;
    kick(32'h0000_0600, 32'h0000_0700, 16'd5, 1'b1, 1'b1);
    step(); step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    checks++; if (BUSY !== 1'b1 || IOBUS_WR !== 1'b0) begin
      errors++; $display("FAIL abort_finish got busy %b wr %b exp 1 0", BUSY, IOBUS_WR); end
    step();
    checks++; if (wr_n - base !== 1 || ABORTED !== 1'b1 || DONE_IRQ !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL abort_done got writes %0d aborted %b irq %b busy %b exp 1 1 1 0",
                         wr_n - base, ABORTED, DONE_IRQ, BUSY); end
    IRQ_CLR = 1'b1; step(); IRQ_CLR = 1'b0;
    checks++; if (ABORTED !== 1'b0 || DONE_IRQ !== 1'b0) begin
      errors++; $display("FAIL abort_clr got aborted %b irq %b exp 0 0", ABORTED, DONE_IRQ); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_zero();
    test_start_ignored();
    test_wrap();
    test_reset_mid();
`ifdef IOBUS_COPY_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
